ccff_bitstream_loader: RTL

Drives a configuration flip-flop (CCFF) chain from its head end, so it is the writer for the chain that every tile exposes as `ccff_head` → `ccff_tail`. The block accepts bitstream words over a valid/ready stream and serializes them LSB first onto `ccff_head`. It gates each chain shift with a clock enable and watches the returning `ccff_tail` to check the chain length before loading. It sits at fabric top level, between the bitstream source and the first tile's `ccff_head`, with the last tile's `ccff_tail` returned to it.

---
 rtl/ccff_bitstream_loader_if.sv | 11 +
 rtl/ccff_bitstream_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream into the CCFF loader: valid/ready handshake, bit 0 shifted first.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Head-end writer for a CCFF chain: clears it, verifies its length with a marker bit,
// then serializes the bitstream LSB first under a per-shift clock enable.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | N shifts of 0 to flush the chain
// CHECK  | N shifts: marker 1 then zeros, tail watched for early marker
// DRAIN  | no shift; tail must now show the marker
// LOAD   | bitstream words serialized onto the chain
// DONE   | chain loaded, holds until start
// ERROR  | chain length mismatch, holds until start
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic                    prog_clk,
    input  logic                    prog_reset,
    input  logic                    start,
    ccff_bitstream_loader_if.slave  word_if,
    output logic                    ccff_head,
    output logic                    chain_clk_en,
    input  logic                    ccff_tail,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W    = $clog2(NWORDS + 1);
    localparam int REM_W     = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(NWORDS - 1);
    localparam logic [WCNT_W-1:0] ALL_WORDS  = WCNT_W'(NWORDS);
    localparam logic [REM_W-1:0]  FULL_REM   = REM_W'(WORD_W);
    localparam logic [REM_W-1:0]  LAST_REM   = REM_W'(LAST_BITS);
    localparam logic [REM_W-1:0]  ONE_REM    = REM_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]        state;
    logic [CNT_W-1:0]  shift_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [REM_W-1:0]  bits_rem;
    logic [WORD_W-1:0] shift_buf;
    logic              accept;

    // bits_rem counts the bit on ccff_head still in flight, so a new word can be
    // taken while the last bit of the previous one shifts out.
    assign word_if.word_ready = (state == S_LOAD) && (bits_rem <= ONE_REM) && (word_cnt < ALL_WORDS);
    assign accept             = word_if.word_valid && word_if.word_ready;

    always_comb begin
        busy  = (state == S_CLEAR) || (state == S_CHECK) || (state == S_DRAIN) || (state == S_LOAD);
        done  = (state == S_DONE);
        error = (state == S_ERROR);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state        <= S_IDLE;
            shift_cnt    <= '0;
            word_cnt     <= '0;
            bits_rem     <= '0;
            shift_buf    <= '0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_CLEAR;
                        shift_cnt    <= '0;
                        word_cnt     <= '0;
                        bits_rem     <= '0;
                        ccff_head    <= 1'b0;
                        chain_clk_en <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (shift_cnt == LAST_SHIFT) begin
                        state     <= S_CHECK;
                        shift_cnt <= '0;
                        ccff_head <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    ccff_head <= 1'b0;
                    // shift_cnt = k shifts already done; tail reflects shift k
                    if ((shift_cnt != '0) && ccff_tail) begin
                        state        <= S_ERROR;
                        chain_clk_en <= 1'b0;
                    end else if (shift_cnt == LAST_SHIFT) begin
                        state        <= S_DRAIN;
                        shift_cnt    <= '0;
                        chain_clk_en <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    shift_cnt <= '0;
                    state     <= ccff_tail ? S_LOAD : S_ERROR;
                end
                S_LOAD: begin
                    if (chain_clk_en) begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                    if (chain_clk_en && (shift_cnt == LAST_SHIFT)) begin
                        state        <= S_DONE;
                        chain_clk_en <= 1'b0;
                        ccff_head    <= 1'b0;
                        bits_rem     <= '0;
                    end else if (accept) begin
                        ccff_head    <= word_if.word_data[0];
                        shift_buf    <= word_if.word_data >> 1;
                        bits_rem     <= (word_cnt == LAST_WORD) ? LAST_REM : FULL_REM;
                        word_cnt     <= word_cnt + 1'b1;
                        chain_clk_en <= 1'b1;
                    end else if (bits_rem > ONE_REM) begin
                        ccff_head    <= shift_buf[0];
                        shift_buf    <= shift_buf >> 1;
                        bits_rem     <= bits_rem - 1'b1;
                        chain_clk_en <= 1'b1;
                    end else begin
                        bits_rem     <= '0;
                        chain_clk_en <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    chain_clk_en <= 1'b0;
                end
            endcase
        end
    end
endmodule
